// File: rtl/axil_byte_master.sv
// axil_byte_master: framed command byte stream in, single AXI-Lite read/write out,
// status and read data returned as a response byte stream.
module axil_byte_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_cmd_tdata,
    input  logic                  s_cmd_tvalid,
    output logic                  s_cmd_tready,
    output logic [7:0]            m_rsp_tdata,
    output logic                  m_rsp_tvalid,
    input  logic                  m_rsp_tready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic                  busy
);
    localparam logic [7:0] OP_WR = 8'h57, OP_RD = 8'h52;
    localparam logic [7:0] ST_OK = 8'h4B, ST_ERR = 8'h45, ST_BAD = 8'h3F;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, TX} state_t;
    state_t state, state_next;
    logic [1:0] idx;
    logic is_wr;
    logic [31:0] addr;
    logic [39:0] rsp;
    logic [2:0] tx_idx, tx_last;
    logic cmd_fire, tx_fire, last_byte, both_done;
    assign s_cmd_tready = !rst && (state == IDLE || state == ADDR || state == DATA);
    assign m_rsp_tvalid = !rst && state == TX;
    assign m_axil_bready = !rst && state == WR_RESP;
    assign m_axil_rready = !rst && state == RD_RESP;
    assign busy = !rst && state != IDLE;
    assign cmd_fire = s_cmd_tvalid && s_cmd_tready;
    assign tx_fire = m_rsp_tvalid && m_rsp_tready;
    assign last_byte = cmd_fire && idx == 2'd3;
    assign both_done = (!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready);
    assign m_rsp_tdata = rsp[{tx_idx, 3'b000} +: 8];
    assign m_axil_awaddr = ADDR_WIDTH'(addr);
    assign m_axil_araddr = ADDR_WIDTH'(addr);
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
    assign m_axil_wstrb = '1;
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = (s_cmd_tdata == OP_WR || s_cmd_tdata == OP_RD) ? ADDR : TX;
            ADDR:    if (last_byte) state_next = is_wr ? DATA : RD_REQ;
            DATA:    if (last_byte) state_next = WR_REQ;
            WR_REQ:  if (both_done) state_next = WR_RESP;
            WR_RESP: if (m_axil_bvalid) state_next = TX;
            RD_REQ:  if (m_axil_arready) state_next = RD_RESP;
            RD_RESP: if (m_axil_rvalid) state_next = TX;
            TX:      if (tx_fire && tx_idx == tx_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    // rsp holds {rdata, status}; tx_last selects how many of its bytes go out
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            is_wr <= 1'b0;
            addr <= '0;
            m_axil_wdata <= '0;
            rsp <= '0;
            tx_idx <= '0;
            tx_last <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid <= 1'b0;
            m_axil_arvalid <= 1'b0;
        end else begin
            if (cmd_fire && state == IDLE) is_wr <= s_cmd_tdata == OP_WR;
            if (cmd_fire && state == ADDR) addr[{idx, 3'b000} +: 8] <= s_cmd_tdata;
            if (cmd_fire && state == DATA) m_axil_wdata[{idx, 3'b000} +: 8] <= s_cmd_tdata;
            if (cmd_fire && state != IDLE) idx <= idx + 2'd1;
            m_axil_awvalid <= (state == DATA && last_byte) || (m_axil_awvalid && !m_axil_awready);
            m_axil_wvalid <= (state == DATA && last_byte) || (m_axil_wvalid && !m_axil_wready);
            m_axil_arvalid <= (state == ADDR && last_byte && !is_wr) || (m_axil_arvalid && !m_axil_arready);
            if (cmd_fire && state == IDLE) begin
                rsp <= {32'h0, ST_BAD};
                tx_last <= 3'd0;
            end
            if (m_axil_bready && m_axil_bvalid) begin
                rsp <= {32'h0, m_axil_bresp == 2'b00 ? ST_OK : ST_ERR};
                tx_last <= 3'd0;
            end
            if (m_axil_rready && m_axil_rvalid) begin
                rsp <= {m_axil_rdata[31:0], m_axil_rresp == 2'b00 ? ST_OK : ST_ERR};
                tx_last <= 3'd4;
            end
            tx_idx <= state != TX ? 3'd0 : !tx_fire ? tx_idx : tx_idx == tx_last ? 3'd0 : tx_idx + 3'd1;
        end
    end
endmodule
